// File: rtl/eq_run_stats_pkg.sv
// ---------------------------------------------------------------------------
// eq_run_stats_pkg
// Shared definitions for the eq_run_stats slice: default widths and the
// saturating-increment helper used by every counter in this codebase.
//
// Contents:
//   CNT_W_DEFAULT       default counter / summary field width
//   RUN_THRESH_DEFAULT  default run length that fires the alarm
//   sat_inc(value, w)   value + 1, held at the all-ones value of a w-bit field
// ---------------------------------------------------------------------------
package eq_run_stats_pkg;

    localparam int CNT_W_DEFAULT      = 16;
    localparam int RUN_THRESH_DEFAULT = 8;

    // Works on a 32-bit carrier so one function serves any counter width up
    // to 32; callers cast the result back down to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : (value + 32'd1);
    endfunction

endpackage

// File: rtl/eq_run_stats_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping. Clear has priority
// over increment so a frame can close and restart on the same beat.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (count -> 0)
//   clear      synchronous clear to 0
//   inc        increment by one, saturating
//   count      current registered value
//   count_inc  saturated count + 1 (combinational), for callers that need the
//              post-increment value in the same cycle
// ---------------------------------------------------------------------------
module sat_counter
    import eq_run_stats_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_inc
);

    assign count_inc = W'(sat_inc(32'(count), W));

    // Clear beats increment: the last beat of a frame both counts and resets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/eq_run_stats.sv
// ---------------------------------------------------------------------------
// eq_run_stats
// Per-frame statistics on the 1-bit match stream from the eq comparator:
// match count, longest consecutive match run and frame length, published as
// a one-entry registered summary over valid/ready. A one-cycle alarm pulses
// when the current run first reaches RUN_THRESH.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   in_z             match flag for this beat
//   in_valid         beat present
//   in_last          final beat of the frame (qualified by in_valid)
//   in_ready         beat accepted when in_valid && in_ready
//   out_match_count  matches in the completed frame
//   out_longest_run  longest run of consecutive matches in the frame
//   out_frame_len    beats in the frame
//   out_valid        summary present
//   out_ready        summary consumed when out_valid && out_ready
//   run_alarm        one-cycle pulse when the current run reaches RUN_THRESH
// ---------------------------------------------------------------------------
module eq_run_stats
    import eq_run_stats_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int RUN_THRESH = RUN_THRESH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_z,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [CNT_W-1:0] out_match_count,
    output logic [CNT_W-1:0] out_longest_run,
    output logic [CNT_W-1:0] out_frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             run_alarm
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(RUN_THRESH);

    logic             accept;
    logic             last_beat;
    logic             match_beat;

    logic [CNT_W-1:0] frame_len;
    logic [CNT_W-1:0] frame_len_inc;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] match_count_inc;
    logic [CNT_W-1:0] cur_run;
    logic [CNT_W-1:0] cur_run_inc;
    logic [CNT_W-1:0] best_run;

    logic [CNT_W-1:0] frame_len_upd;
    logic [CNT_W-1:0] match_count_upd;
    logic [CNT_W-1:0] cur_run_upd;
    logic [CNT_W-1:0] best_run_upd;

    // The one-entry buffer frees up in the same cycle it is drained, which is
    // what gives back-to-back frames without a bubble.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_beat  = accept && in_last;
    assign match_beat = accept && in_z;

    sat_counter #(.W(CNT_W)) u_frame_len (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (last_beat),
        .inc       (accept),
        .count     (frame_len),
        .count_inc (frame_len_inc)
    );

    sat_counter #(.W(CNT_W)) u_match_count (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (last_beat),
        .inc       (match_beat),
        .count     (match_count),
        .count_inc (match_count_inc)
    );

    // A non-matching beat breaks the run; the frame end also restarts it.
    sat_counter #(.W(CNT_W)) u_cur_run (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept && (in_last || !in_z)),
        .inc       (match_beat),
        .count     (cur_run),
        .count_inc (cur_run_inc)
    );

    // Values as they stand after applying the current beat; on the last beat
    // these go to the summary while the accumulators themselves clear.
    always_comb begin
        frame_len_upd   = accept ? frame_len_inc : frame_len;
        match_count_upd = in_z ? match_count_inc : match_count;
        cur_run_upd     = in_z ? cur_run_inc : '0;
        best_run_upd    = (cur_run_upd > best_run) ? cur_run_upd : best_run;
    end

    // Longest run so far in this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_run <= '0;
        end else if (last_beat) begin
            best_run <= '0;
        end else if (accept) begin
            best_run <= best_run_upd;
        end
    end

    // Summary buffer: data holds after a consume, only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_match_count <= '0;
            out_longest_run <= '0;
            out_frame_len   <= '0;
            out_valid       <= 1'b0;
        end else if (last_beat) begin
            out_match_count <= match_count_upd;
            out_longest_run <= best_run_upd;
            out_frame_len   <= frame_len_upd;
            out_valid       <= 1'b1;
        end else if (out_ready) begin
            out_valid       <= 1'b0;
        end
    end

    // Fire only on the step into THRESH; a saturated run sitting at THRESH
    // (cur_run_inc == cur_run) must not refire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_alarm <= 1'b0;
        end else begin
            run_alarm <= match_beat && (cur_run_inc == THRESH) && (cur_run != THRESH);
        end
    end

endmodule
